if_stage: RTL and testbench

- Instruction fetch stage directly upstream of id_stage.
- Holds the PC and issues single-outstanding requests to the instruction memory port.
- Buffers one fetched instruction in an output slot with a valid/ready handshake toward ID.
- Handles redirects from branch/jump resolution and the exception handler, including killing an in-flight fetch.
- Reports instruction-address-misaligned and instruction-access-fault conditions to ID for the exception path.

---
 rtl/if_stage.sv | 143 ++++++++++++++
 tb/tb_if_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_stage : PC, single-outstanding imem fetch, one-entry slot toward ID    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module if_stage #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  input  logic        redirect_vld_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        inst_vld_o,
  output logic [31:0] inst_o,
  output logic [63:0] inst_addr_o,
  output logic [1:0]  fetch_excp_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DROP  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] drop_addr_q, drop_addr_d;
  logic        pend_q, pend_d;
  logic        vld_q, vld_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  excp_q, excp_d;

  logic slot_open;
  logic misaligned;

  assign slot_open  = ~vld_q | id_ready_i;
  assign misaligned = (pc_q[1:0] != 2'b00);

  // A killed request keeps its original address on the bus while pc moves on.
  assign imem_req_o  = ~rst & ((state_q == S_DROP) |
                       ((state_q == S_FETCH) & ~misaligned & (pend_q | slot_open)));
  assign imem_addr_o = (state_q == S_DROP) ? drop_addr_q : pc_q;

  assign inst_vld_o   = vld_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = addr_q;
  assign fetch_excp_o = excp_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    pend_d      = pend_q;
    vld_d       = vld_q;
    inst_d      = inst_q;
    addr_d      = addr_q;
    excp_d      = excp_q;

    if (vld_q && id_ready_i) begin
      vld_d = 1'b0;
    end

    if (redirect_vld_i) begin
      pc_d  = redirect_pc_i;
      vld_d = 1'b0;
      if (imem_req_o && !imem_ack_i) begin
        state_d     = S_DROP;
        pend_d      = 1'b1;
        drop_addr_d = imem_addr_o;
      end else begin
        state_d = S_FETCH;
        pend_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (misaligned && slot_open) begin
            vld_d   = 1'b1;
            inst_d  = NOP_INST;
            addr_d  = pc_q;
            excp_d  = 2'b01;
            state_d = S_HALT;
          end else if (imem_req_o && imem_ack_i) begin
            vld_d  = 1'b1;
            addr_d = pc_q;
            pend_d = 1'b0;
            if (imem_err_i) begin
              inst_d  = NOP_INST;
              excp_d  = 2'b10;
              state_d = S_HALT;
            end else begin
              inst_d = imem_rdata_i;
              excp_d = 2'b00;
              pc_d   = pc_q + 64'd4;
            end
          end else if (imem_req_o) begin
            pend_d = 1'b1;
          end
        end
        S_DROP: begin
          if (imem_ack_i) begin
            pend_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= PC_RESET;
      drop_addr_q <= 64'd0;
      pend_q      <= 1'b0;
      vld_q       <= 1'b0;
      inst_q      <= NOP_INST;
      addr_q      <= 64'd0;
      excp_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      pend_q      <= pend_d;
      vld_q       <= vld_d;
      inst_q      <= inst_d;
      addr_q      <= addr_d;
      excp_q      <= excp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_if_stage : vector table plus scoreboarded redirect/exception sequences |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_vld;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        inst_vld;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic [1:0]  fetch_excp;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .imem_err_i    (imem_err),
    .redirect_vld_i(redirect_vld),
    .redirect_pc_i (redirect_pc),
    .id_ready_i    (id_ready),
    .inst_vld_o    (inst_vld),
    .inst_o        (inst),
    .inst_addr_o   (inst_addr),
    .fetch_excp_o  (fetch_excp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: fixed wait count, data derived from address, optional fault address.
  int          waits;
  int          cnt;
  bit          err_en;
  logic [63:0] err_addr;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always_comb begin
    imem_ack   = imem_req && (cnt >= waits);
    imem_rdata = memf(imem_addr);
    imem_err   = imem_ack && err_en && (imem_addr == err_addr);
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [63:0] addr;
    logic [1:0]  excp;
  } exp_t;

  exp_t sbq[$];
  bit   sb_en;

  task automatic sb_check();
    exp_t e;
    if (sb_en && inst_vld && id_ready && !redirect_vld) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got inst_addr %h expected no handshake", inst_addr);
      end else begin
        e = sbq.pop_front();
        chk("sb_inst", {32'd0, inst}, {32'd0, e.inst});
        chk("sb_addr", inst_addr, e.addr);
        chk("sb_excp", {62'd0, fetch_excp}, {62'd0, e.excp});
      end
    end
  endtask

  task automatic cycle(input bit rdy, input bit rv, input logic [63:0] rpc);
    @(negedge clk);
    id_ready     = rdy;
    redirect_vld = rv;
    redirect_pc  = rpc;
    #2;
    sb_check();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    id_ready     = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = 64'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && sbq.size() > 0; k++) cycle(1'b1, 1'b0, 64'd0);
    chk(name, 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  typedef struct {
    bit          rst_first;
    bit          rdy;
    bit          exp_req;
    logic [63:0] exp_addr;
    bit          exp_vld;
    logic [63:0] exp_ia;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 64'h8000_000C, 1'b1, 64'h8000_0008};

    n_chk    = 0;
    n_fail   = 0;
    sb_en    = 1'b0;
    waits    = 0;
    err_en   = 1'b0;
    err_addr = 64'd0;

    rst = 1'b1; id_ready = 1'b0; redirect_vld = 1'b0; redirect_pc = 64'd0;
    #2;
    chk("rst_req",  {63'd0, imem_req}, 64'd0);
    chk("rst_vld",  {63'd0, inst_vld}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'h13);
    chk("rst_ia",   inst_addr, 64'd0);
    chk("rst_excp", {62'd0, fetch_excp}, 64'd0);

    // Zero-wait streaming and back-pressure.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_first) do_reset();
      cycle(tbl[i].rdy, 1'b0, 64'd0);
      chk($sformatf("tbl%0d_req", i),  {63'd0, imem_req}, {63'd0, tbl[i].exp_req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_vld", i),  {63'd0, inst_vld}, {63'd0, tbl[i].exp_vld});
      if (tbl[i].exp_vld) begin
        chk($sformatf("tbl%0d_ia", i),   inst_addr, tbl[i].exp_ia);
        chk($sformatf("tbl%0d_inst", i), {32'd0, inst}, {32'd0, memf(tbl[i].exp_ia)});
        chk($sformatf("tbl%0d_excp", i), {62'd0, fetch_excp}, 64'd0);
      end
    end

    sb_en = 1'b1;

    // Redirect during a 3-wait fetch: old request completes and is discarded.
    waits = 3;
    do_reset();
    cycle(1'b1, 1'b0, 64'd0);
    chk("A_req0", {63'd0, imem_req}, 64'd1);
    cycle(1'b1, 1'b1, 64'h8000_1000);
    chk("A_addr1", imem_addr, 64'h8000_0000);
    for (int k = 2; k < 4; k++) begin
      cycle(1'b1, 1'b0, 64'd0);
      chk($sformatf("A_addr%0d", k), imem_addr, 64'h8000_0000);
      chk($sformatf("A_vld%0d", k), {63'd0, inst_vld}, 64'd0);
    end
    chk("A_ack3", {63'd0, imem_ack}, 64'd1);
    sbq.push_back('{memf(64'h8000_1000), 64'h8000_1000, 2'b00});
    cycle(1'b1, 1'b0, 64'd0);
    chk("A_addr4", imem_addr, 64'h8000_1000);
    chk("A_vld4", {63'd0, inst_vld}, 64'd0);
    drain("A_drain");

    // Redirect coincident with ack.
    waits = 2;
    do_reset();
    cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b1, 1'b0, 64'd0);
    cycle(1'b1, 1'b1, 64'h8000_2000);
    chk("B_ack", {63'd0, imem_ack}, 64'd1);
    sbq.push_back('{memf(64'h8000_2000), 64'h8000_2000, 2'b00});
    cycle(1'b1, 1'b0, 64'd0);
    chk("B_addr", imem_addr, 64'h8000_2000);
    chk("B_vld", {63'd0, inst_vld}, 64'd0);
    drain("B_drain");

    // Misaligned redirect target.
    waits = 0;
    do_reset();
    cycle(1'b0, 1'b1, 64'h8000_0102);
    sbq.push_back('{32'h0000_0013, 64'h8000_0102, 2'b01});
    cycle(1'b0, 1'b0, 64'd0);
    chk("C_req1", {63'd0, imem_req}, 64'd0);
    cycle(1'b0, 1'b0, 64'd0);
    chk("C_vld", {63'd0, inst_vld}, 64'd1);
    chk("C_excp", {62'd0, fetch_excp}, 64'd1);
    chk("C_ia", inst_addr, 64'h8000_0102);
    chk("C_inst", {32'd0, inst}, 64'h13);
    chk("C_req2", {63'd0, imem_req}, 64'd0);
    cycle(1'b1, 1'b0, 64'd0);
    chk("C_req3", {63'd0, imem_req}, 64'd0);
    cycle(1'b1, 1'b0, 64'd0);
    chk("C_req4", {63'd0, imem_req}, 64'd0);
    chk("C_vld4", {63'd0, inst_vld}, 64'd0);
    cycle(1'b1, 1'b1, 64'h8000_0200);
    chk("C_req5", {63'd0, imem_req}, 64'd0);
    cycle(1'b1, 1'b0, 64'd0);
    chk("C_req6", {63'd0, imem_req}, 64'd1);
    chk("C_addr6", imem_addr, 64'h8000_0200);
    chk("C_sbq", 64'(sbq.size()), 64'd0);

    // Access fault, halt, then async reset mid-wait.
    waits    = 0;
    err_en   = 1'b1;
    err_addr = 64'h8000_0010;
    do_reset();
    cycle(1'b1, 1'b1, 64'h8000_0010);
    @(posedge clk);
    #1 waits = 1;
    cycle(1'b1, 1'b0, 64'd0);
    chk("D_addr1", imem_addr, 64'h8000_0010);
    cycle(1'b1, 1'b0, 64'd0);
    chk("D_err", {63'd0, imem_err}, 64'd1);
    sbq.push_back('{32'h0000_0013, 64'h8000_0010, 2'b10});
    cycle(1'b1, 1'b0, 64'd0);
    chk("D_vld", {63'd0, inst_vld}, 64'd1);
    chk("D_excp", {62'd0, fetch_excp}, 64'd2);
    chk("D_req3", {63'd0, imem_req}, 64'd0);
    cycle(1'b1, 1'b0, 64'd0);
    chk("D_req4", {63'd0, imem_req}, 64'd0);
    chk("D_vld4", {63'd0, inst_vld}, 64'd0);
    cycle(1'b1, 1'b1, 64'h8000_0020);
    chk("D_req5", {63'd0, imem_req}, 64'd0);
    waits = 3;
    cycle(1'b1, 1'b0, 64'd0);
    chk("D_addr6", imem_addr, 64'h8000_0020);
    chk("D_req6", {63'd0, imem_req}, 64'd1);
    cycle(1'b1, 1'b0, 64'd0);
    rst = 1'b1;
    #1;
    chk("D_rst_req", {63'd0, imem_req}, 64'd0);
    chk("D_rst_addr", imem_addr, 64'h8000_0000);
    chk("D_rst_vld", {63'd0, inst_vld}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b1, 1'b0, 64'd0);
    chk("D_refetch_req", {63'd0, imem_req}, 64'd1);
    chk("D_refetch_addr", imem_addr, 64'h8000_0000);
    chk("D_sbq", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
